// File: rtl/splash_position_controller.sv
// Hammer-splash placement: clamps a hit to a sprite top-left, holds it for a frame-counted
// show window (retriggerable, with cooldown), and emits a RAM-latency-aligned pixel_visible.
module splash_position_controller #(
  parameter int SPRITE_W        = 100,
  parameter int SPRITE_H        = 100,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SHOW_FRAMES     = 30,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int PIPE_DELAY      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] hit_x,
  input  logic [8:0] hit_y,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic       active,
  output logic       pixel_visible,
  output logic       done
);

  localparam logic [10:0] HALF_W = 11'(SPRITE_W / 2);
  localparam logic [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] SPR_W  = 11'(SPRITE_W);
  localparam logic [9:0]  HALF_H = 10'(SPRITE_H / 2);
  localparam logic [9:0]  MAX_Y  = 10'(SCREEN_H - SPRITE_H);
  localparam logic [9:0]  SPR_H  = 10'(SPRITE_H);

  localparam int CNT_MAX = (SHOW_FRAMES > COOLDOWN_FRAMES) ? SHOW_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHOW, COOL} state_t;

  function automatic logic [9:0] clamp_left(input logic [9:0] cx);
    logic [10:0] left;
    left = ({1'b0, cx} >= HALF_W) ? ({1'b0, cx} - HALF_W) : 11'd0;
    if (left > MAX_X) left = MAX_X;
    return left[9:0];
  endfunction

  function automatic logic [8:0] clamp_top(input logic [8:0] cy);
    logic [9:0] top;
    top = ({1'b0, cy} >= HALF_H) ? ({1'b0, cy} - HALF_H) : 10'd0;
    if (top > MAX_Y) top = MAX_Y;
    return top[8:0];
  endfunction

  state_t           state, next_state;
  logic [9:0]       pend_x, hit_cx;
  logic [8:0]       pend_y, hit_cy;
  logic             retrig, retrig_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cap_pend, load_sprite, load_from_hit;
  logic             active_nxt, done_nxt, expire;

  assign hit_cx = clamp_left(hit_x);
  assign hit_cy = clamp_top(hit_y);
  assign expire = frame_tick && !retrig && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hit) next_state = ARM;
      ARM:     if (frame_tick) next_state = SHOW;
      SHOW:    if (expire) next_state = (COOLDOWN_FRAMES == 0) ? IDLE : COOL;
      COOL:    if (frame_tick && cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cap_pend      = 1'b0;
    load_sprite   = 1'b0;
    load_from_hit = 1'b0;
    cnt_nxt       = cnt;
    retrig_nxt    = 1'b0;
    active_nxt    = active;
    done_nxt      = 1'b0;
    case (state)
      IDLE: cap_pend = hit;
      ARM: begin
        cap_pend = hit;
        if (frame_tick) begin
          load_sprite   = 1'b1;
          load_from_hit = hit;
          active_nxt    = 1'b1;
          cnt_nxt       = SHOW_LOAD;
        end
      end
      SHOW: begin
        cap_pend   = hit;
        retrig_nxt = retrig;
        if (frame_tick) begin
          // A pending retrigger outranks expiry; a same-cycle hit arms the following tick.
          if (retrig) begin
            load_sprite = 1'b1;
            cnt_nxt     = SHOW_LOAD;
            retrig_nxt  = 1'b0;
          end else if (cnt == '0) begin
            active_nxt = 1'b0;
            done_nxt   = 1'b1;
            cnt_nxt    = COOL_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        if (hit && !expire) retrig_nxt = 1'b1;
      end
      COOL: if (frame_tick && cnt != '0) cnt_nxt = cnt - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_x   <= '0;
      pend_y   <= '0;
      sprite_x <= '0;
      sprite_y <= '0;
      retrig   <= 1'b0;
      cnt      <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (cap_pend) begin
        pend_x <= hit_cx;
        pend_y <= hit_cy;
      end
      if (load_sprite) begin
        sprite_x <= load_from_hit ? hit_cx : pend_x;
        sprite_y <= load_from_hit ? hit_cy : pend_y;
      end
      retrig <= retrig_nxt;
      cnt    <= cnt_nxt;
      active <= active_nxt;
      done   <= done_nxt;
    end
  end

  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic        vis_raw;

  assign x_end   = {1'b0, sprite_x} + SPR_W;
  assign y_end   = {1'b0, sprite_y} + SPR_H;
  assign vis_raw = active && (x >= sprite_x) && ({1'b0, x} < x_end)
                          && (y >= sprite_y) && ({1'b0, y} < y_end);

  generate
    if (PIPE_DELAY == 0) begin : g_nopipe
      assign pixel_visible = vis_raw;
    end else begin : g_pipe
      logic vis_pipe [PIPE_DELAY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) vis_pipe[i] <= 1'b0;
        end else begin
          vis_pipe[0] <= vis_raw;
          for (int i = 1; i < PIPE_DELAY; i++) vis_pipe[i] <= vis_pipe[i-1];
        end
      end
      assign pixel_visible = vis_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_splash_position_controller.sv
// Scoreboard bench for splash_position_controller at default parameters.
module tb_splash_position_controller;

  logic       clk = 1'b0;
  logic       reset, frame_tick, hit;
  logic [9:0] hit_x, x;
  logic [8:0] hit_y, y;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic       active, pixel_visible, done;

  always #5 clk = ~clk;

  splash_position_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .hit(hit),
    .hit_x(hit_x), .hit_y(hit_y), .x(x), .y(y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .active(active),
    .pixel_visible(pixel_visible), .done(done)
  );

  localparam int SX = 0, SY = 1, ACT = 2, DN = 3, PV = 4;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int clamp_tab [6][4] = '{
    '{10, 5, 0, 0}, '{639, 479, 540, 380}, '{50, 50, 0, 0},
    '{590, 430, 540, 380}, '{51, 51, 1, 1}, '{589, 429, 539, 379}
  };

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input int sx, input int sy, input int act, input int dn);
    expect_o({tag, "_sx"}, SX, sx);
    expect_o({tag, "_sy"}, SY, sy);
    expect_o({tag, "_act"}, ACT, act);
    expect_o({tag, "_done"}, DN, dn);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SX:      got = 32'(sprite_x);
        SY:      got = 32'(sprite_y);
        ACT:     got = 32'(active);
        DN:      got = 32'(done);
        default: got = 32'(pixel_visible);
      endcase
      check_val(e.tag, got, 32'(e.val));
    end
  endtask

  task automatic cyc(input logic h, input int hx, input int hy, input logic t);
    hit        = h;
    hit_x      = 10'(hx);
    hit_y      = 9'(hy);
    frame_tick = t;
    @(posedge clk);
    #1;
    hit        = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 0, 0, 1'b1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    hit        = 1'b0;
    frame_tick = 1'b0;
    x          = '0;
    y          = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pix(input string tag, input int px, input int py, input int expv);
    x = 10'(px);
    y = 9'(py);
    idle_cyc();
    expect_o(tag, PV, expv);
    idle_cyc();
    drain();
  endtask

  task automatic run_lifetime(input string tag);
    for (int k = 1; k <= 30; k++) begin
      expect_o($sformatf("%s_act_%0d", tag, k), ACT, int'(k < 30));
      expect_o($sformatf("%s_done_%0d", tag, k), DN, int'(k == 30));
      tick();
      drain();
      expect_o($sformatf("%s_done_clr_%0d", tag, k), DN, 0);
      idle_cyc();
      drain();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    hit_x = '0;
    hit_y = '0;
    do_reset();
    expect_all("reset", 0, 0, 0, 0);
    expect_o("reset_pv", PV, 0);
    drain();

    // Basic capture, load and pixel window
    expect_o("arm_inactive", ACT, 0);
    cyc(1'b1, 320, 240, 1'b0);
    drain();
    expect_all("load", 270, 190, 1, 0);
    tick();
    drain();
    x = 10'd270;
    y = 9'd190;
    expect_o("pv_delay1", PV, 0);
    idle_cyc();
    drain();
    expect_o("pv_delay2", PV, 1);
    idle_cyc();
    drain();
    pix("pv_br_inside", 369, 289, 1);
    pix("pv_x_past", 370, 190, 0);
    pix("pv_y_past", 270, 290, 0);
    pix("pv_left_out", 269, 190, 0);

    // Reset with visible pixels in flight
    pix("pre_rst_pv", 270, 190, 1);
    reset = 1'b1;
    expect_all("mid_rst", 0, 0, 0, 0);
    expect_o("mid_rst_pv", PV, 0);
    idle_cyc();
    drain();
    reset = 1'b0;

    foreach (clamp_tab[i]) begin
      do_reset();
      cyc(1'b1, clamp_tab[i][0], clamp_tab[i][1], 1'b0);
      expect_o($sformatf("clamp%0d_sx", i), SX, clamp_tab[i][2]);
      expect_o($sformatf("clamp%0d_sy", i), SY, clamp_tab[i][3]);
      tick();
      drain();
    end

    // Right/bottom screen edge: sprite at (540,380) covers up to 639,479
    do_reset();
    cyc(1'b1, 639, 479, 1'b0);
    tick();
    pix("pv_far_corner", 639, 479, 1);
    pix("pv_tl_corner", 540, 380, 1);
    pix("pv_x_before", 539, 380, 0);

    // Lifetime, expiry and cooldown
    do_reset();
    cyc(1'b1, 320, 240, 1'b0);
    expect_o("life_load_act", ACT, 1);
    tick();
    drain();
    run_lifetime("life");
    for (int c = 1; c <= 4; c++) begin
      expect_o($sformatf("cool_hit_act_%0d", c), ACT, 0);
      cyc(1'b1, 100, 100, 1'b0);
      drain();
      expect_o($sformatf("cool_tick_act_%0d", c), ACT, 0);
      expect_o($sformatf("cool_tick_sx_%0d", c), SX, 270);
      tick();
      drain();
    end
    expect_o("idle_tick_act", ACT, 0);
    expect_o("idle_tick_sx", SX, 270);
    tick();
    drain();
    cyc(1'b1, 100, 100, 1'b0);
    expect_all("rearm", 50, 50, 1, 0);
    tick();
    drain();

    // Retrigger reloads position and lifetime
    do_reset();
    cyc(1'b1, 100, 100, 1'b0);
    expect_o("rt_first_sx", SX, 50);
    tick();
    drain();
    for (int k = 1; k <= 10; k++) begin
      expect_o($sformatf("rt_pre_act_%0d", k), ACT, 1);
      tick();
      drain();
    end
    expect_o("rt_hold_sx", SX, 50);
    cyc(1'b1, 400, 300, 1'b0);
    drain();
    expect_all("rt_load", 350, 250, 1, 0);
    tick();
    drain();
    run_lifetime("rt");

    // Hit coinciding with tick in ARM bypasses pending
    do_reset();
    cyc(1'b1, 500, 400, 1'b0);
    expect_all("arm_bypass", 150, 150, 1, 0);
    cyc(1'b1, 200, 200, 1'b1);
    drain();

    // Hit coinciding with tick in IDLE only arms
    do_reset();
    expect_all("idle_hit_tick", 0, 0, 0, 0);
    cyc(1'b1, 320, 240, 1'b1);
    drain();
    expect_all("idle_then_tick", 270, 190, 1, 0);
    tick();
    drain();

    // Hit coinciding with tick in SHOW takes effect one tick later
    expect_all("show_hit_tick", 270, 190, 1, 0);
    cyc(1'b1, 600, 50, 1'b1);
    drain();
    expect_all("show_next_tick", 540, 0, 1, 0);
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/splash_position_controller.md
Name: splash_position_controller

Overview:
Sits directly upstream of the 100x100 hammer-splash image setter. It turns a one-cycle hit event at a screen coordinate into the splash sprite's top-left coordinates and a timed, frame-synchronous visibility window. It also emits a per-pixel visibility flag, delayed to line up with the setter's two-stage image/palette RAM latency, so the downstream pixel mux can gate the setter's 12-bit colour output directly.

Parameters:
SPRITE_W, 100, sprite width in pixels
SPRITE_H, 100, sprite height in pixels
SCREEN_W, 640, visible screen width
SCREEN_H, 480, visible screen height
SHOW_FRAMES, 30, frames the splash stays visible (>=1)
COOLDOWN_FRAMES, 4, frames after expiry during which hits are dropped (>=0)
PIPE_DELAY, 2, cycles of delay on pixel_visible, matching the image setter's RAM latency

Ports:
clk  in  1  system pixel-domain clock, rising edge
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per frame at start of vertical blank
hit  in  1  one-cycle pulse: hammer hit occurred
hit_x  in  10  hit centre x, 0..639
hit_y  in  9  hit centre y, 0..479
x  in  10  current scan pixel x
y  in  9  current scan pixel y
sprite_x  out  10  splash top-left x, drives the image setter's x-coordinate input
sprite_y  out  9  splash top-left y, drives the image setter's y-coordinate input
active  out  1  splash currently displayed
pixel_visible  out  1  (x,y) inside splash box while active, delayed PIPE_DELAY cycles
done  out  1  one-cycle pulse when a show window expires

Behaviour:
- Reset (synchronous, active-high): state=IDLE; sprite_x=0, sprite_y=0, active=0, done=0; pixel_visible pipeline cleared to 0; pending registers=0; frame counter=0.
- Position clamp, computed on capture:
  - left = hit_x - SPRITE_W/2 if hit_x >= SPRITE_W/2, else 0; then min(left, SCREEN_W-SPRITE_W). This bounds left to 0..540.
  - top is the same using SPRITE_H and SCREEN_H, bounded to 0..380.
  - Compute in 11-bit / 10-bit intermediates so there is no wrap.
  - The result goes to the pending registers (pend_x, pend_y).
- sprite_x and sprite_y change only on a frame_tick cycle, so the image never tears mid-frame. They hold their last value when inactive.
- States:
  - IDLE:
    - hit -> capture pending, go ARM.
    - frame_tick on the same cycle as hit is ignored; the FSM still goes to ARM.
  - ARM:
    - hit -> recapture pending (latest hit wins).
    - frame_tick -> sprite_x/y <= pending, active<=1, counter<=SHOW_FRAMES-1, go SHOW.
    - hit and frame_tick on the same cycle: the new hit's clamped coordinates bypass pending and are loaded.
  - SHOW:
    - hit -> capture pending, set retrig flag.
    - On frame_tick, if retrig is set: load pending into sprite_x/y, counter<=SHOW_FRAMES-1, clear retrig, stay in SHOW. Retrigger has priority over expiry.
    - On frame_tick, else if counter==0: active<=0, done<=1 for one cycle, counter<=COOLDOWN_FRAMES-1, go COOL. If COOLDOWN_FRAMES==0, go IDLE instead.
    - On frame_tick, otherwise: counter decrements.
    - hit and frame_tick on the same cycle: the tick acts on the prior retrig state, and the hit sets retrig for the next tick.
  - COOL:
    - hit is dropped.
    - frame_tick with counter==0 -> IDLE; otherwise the counter decrements.
- done is 0 except for the single cycle after the expiring frame_tick (registered).
- Latency: active and sprite_x/y update on the clock edge that samples frame_tick.
- pixel_visible:
  - raw = active && x>=sprite_x && x<sprite_x+SPRITE_W && y>=sprite_y && y<sprite_y+SPRITE_H. Comparisons use widened sums, so sprite_x=540 gives an upper bound of 640 with no overflow.
  - raw is passed through a PIPE_DELAY-stage register chain and pixel_visible is the last stage.
  - PIPE_DELAY=0 means combinational passthrough.
- Reset mid-show: next cycle the FSM is IDLE with all outputs 0; any in-flight pixel_visible bits are flushed.

Test Plan:
- Reset, then hit at (320,240), then frame_tick -> sprite_x=270, sprite_y=190, active=1 one cycle after the tick. With x=270,y=190: pixel_visible=1 two cycles later. With x=370,y=190: pixel_visible=0.
- Corner clamps: hit (10,5) -> (0,0). Hit (639,479) -> (540,380). Hit (50,50) -> (0,0). Hit (590,430) -> (540,380).
- Lifetime with SHOW_FRAMES=30, COOLDOWN_FRAMES=4:
  - active stays high for exactly 30 frame_ticks after the loading tick.
  - done pulses once on expiry.
  - A hit during the next 4 ticks is ignored (state stays COOL/IDLE, sprite_x unchanged).
  - A hit after the 4th tick re-arms.
- Retrigger: hit (100,100), then tick, then 10 ticks; hit (400,300), then tick -> sprite=(350,250), counter reloaded, and active lasts 30 more ticks with no done pulse in between.
- Simultaneous events:
  - In ARM, hit (200,200) on the same cycle as tick after a pending (500,400) -> sprite=(150,150).
  - In IDLE, hit with tick on the same cycle -> state ARM, active=0.
- Reset asserted mid-SHOW with pixel_visible=1 in the pipe -> next cycle active=0, pixel_visible=0, done=0, and the sprite coordinates are 0.
